// File: rtl/dsp19x2_fir_sequencer.sv
// ---------------------------------------------------------------------------
// dsp19x2_fir_sequencer
//
// Time-multiplexed dual-lane FIR controller for one DSP19X2 configured as a
// multiply-accumulate unit with input and output registers. One shared
// coefficient bank and one delay line per lane live here. For each accepted
// sample pair the block streams NUM_TAPS MAC cycles into the DSP, lets the
// DSP pipeline drain, captures both accumulator results and offers them on a
// valid/ready handshake. It owns every DSP control input.
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   s_valid_i / s_ready_o       sample handshake
//   s_data1_i, s_data2_i        9-bit lane samples
//   coef_we_i / coef_ready_o    coefficient write handshake
//   coef_addr_i, coef_data_i    tap index (4 bit), coefficient (10 bit)
//   dsp_a1_o, dsp_a2_o          coefficient to the DSP (10 bit)
//   dsp_b1_o, dsp_b2_o          delayed sample to the DSP (9 bit)
//   dsp_load_acc_o              accumulator load (first tap)
//   dsp_feedback_o ... acc_fir  static DSP configuration
//   dsp_z1_i, dsp_z2_i          DSP results (19 bit)
//   m_valid_o / m_ready_i       result handshake
//   m_data1_o, m_data2_o        filtered results (19 bit)
//   busy_o                      high while taps are issued or the DSP drains
// ---------------------------------------------------------------------------
module dsp19x2_fir_sequencer #(
  parameter int NUM_TAPS    = 8,
  parameter int SHIFT       = 0,
  parameter int PIPE_LAT    = 2,
  parameter int SIGNED_DATA = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [8:0]  s_data1_i,
  input  logic [8:0]  s_data2_i,
  input  logic        coef_we_i,
  output logic        coef_ready_o,
  input  logic [3:0]  coef_addr_i,
  input  logic [9:0]  coef_data_i,
  output logic [9:0]  dsp_a1_o,
  output logic [9:0]  dsp_a2_o,
  output logic [8:0]  dsp_b1_o,
  output logic [8:0]  dsp_b2_o,
  output logic        dsp_load_acc_o,
  output logic [2:0]  dsp_feedback_o,
  output logic        dsp_subtract_o,
  output logic        dsp_saturate_o,
  output logic        dsp_round_o,
  output logic [4:0]  dsp_shift_right_o,
  output logic        dsp_unsigned_a_o,
  output logic        dsp_unsigned_b_o,
  output logic [4:0]  dsp_acc_fir_o,
  input  logic [18:0] dsp_z1_i,
  input  logic [18:0] dsp_z2_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [18:0] m_data1_o,
  output logic [18:0] m_data2_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_OUT} state_e;

  localparam logic [3:0] K_LAST = 4'(NUM_TAPS - 1);
  localparam logic [1:0] D_LAST = 2'(PIPE_LAT - 1);

  state_e      state_q;
  logic [3:0]  k_q;        // index of the tap currently on the DSP inputs
  logic [3:0]  k_d;
  logic [1:0]  drain_q;
  logic        s_ready_q;
  logic        coef_ready_q;
  logic        m_valid_q;
  logic        busy_q;
  logic [9:0]  dsp_a_q;
  logic [8:0]  dsp_b1_q;
  logic [8:0]  dsp_b2_q;
  logic        load_q;
  logic [18:0] m_data1_q;
  logic [18:0] m_data2_q;

  logic [9:0]  coef_q [NUM_TAPS];
  logic [8:0]  x1_q   [NUM_TAPS];
  logic [8:0]  x2_q   [NUM_TAPS];

  logic        accept;
  logic        coef_wr;
  logic [9:0]  tap0_coef;
  logic [9:0]  nxt_coef;
  logic [8:0]  nxt_x1;
  logic [8:0]  nxt_x2;

  // s_ready_q is high only in IDLE, coef_ready_q only in IDLE and OUT.
  assign accept  = s_ready_q & s_valid_i;
  assign coef_wr = coef_ready_q & coef_we_i;
  assign k_d     = k_q + 4'd1;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nxt_coef = '0;
    nxt_x1   = '0;
    nxt_x2   = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (k_d == 4'(i)) begin
        nxt_coef = coef_q[i];
        nxt_x1   = x1_q[i];
        nxt_x2   = x2_q[i];
      end
    end
    // A write to tap 0 on the accept edge must already feed the first MAC.
    tap0_coef = (coef_wr && coef_addr_i == 4'd0) ? coef_data_i : coef_q[0];
  end

  // Coefficient bank and delay lines. Out-of-range addresses match no entry
  // and are therefore ignored.
  // NOTE: these small flop arrays are cleared on reset on purpose: a
  // restarted filter must not see stale history or old coefficients.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= '0;
        x1_q[i]   <= '0;
        x2_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (coef_wr && coef_addr_i == 4'(i)) coef_q[i] <= coef_data_i;
      end
      if (accept) begin
        for (int i = NUM_TAPS - 1; i > 0; i--) begin
          x1_q[i] <= x1_q[i-1];
          x2_q[i] <= x2_q[i-1];
        end
        x1_q[0] <= s_data1_i;
        x2_q[0] <= s_data2_i;
      end
    end
  end

  // Sequencer. DSP inputs are registered, so each branch loads the values
  // the DSP must see in the following cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      drain_q      <= '0;
      s_ready_q    <= 1'b1;
      coef_ready_q <= 1'b1;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      dsp_a_q      <= '0;
      dsp_b1_q     <= '0;
      dsp_b2_q     <= '0;
      load_q       <= 1'b0;
      m_data1_q    <= '0;
      m_data2_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_MAC;
            k_q          <= '0;
            s_ready_q    <= 1'b0;
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            // Tap 0 uses the incoming sample, which is x[0] after the shift.
            dsp_a_q      <= tap0_coef;
            dsp_b1_q     <= s_data1_i;
            dsp_b2_q     <= s_data2_i;
            load_q       <= 1'b1;
          end
        end
        ST_MAC: begin
          load_q <= 1'b0;
          if (k_q == K_LAST) begin
            state_q  <= ST_DRAIN;
            drain_q  <= '0;
            dsp_a_q  <= '0;
            dsp_b1_q <= '0;
            dsp_b2_q <= '0;
          end else begin
            k_q      <= k_d;
            dsp_a_q  <= nxt_coef;
            dsp_b1_q <= nxt_x1;
            dsp_b2_q <= nxt_x2;
          end
        end
        ST_DRAIN: begin
          // Zero operands keep the accumulator unchanged while the last
          // product works its way to DSP_Z.
          if (drain_q == D_LAST) begin
            state_q      <= ST_OUT;
            m_data1_q    <= dsp_z1_i;
            m_data2_q    <= dsp_z2_i;
            m_valid_q    <= 1'b1;
            busy_q       <= 1'b0;
            coef_ready_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_OUT: begin
          if (m_ready_i) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready_o         = s_ready_q;
  assign coef_ready_o      = coef_ready_q;
  assign m_valid_o         = m_valid_q;
  assign busy_o            = busy_q;
  assign m_data1_o         = m_data1_q;
  assign m_data2_o         = m_data2_q;
  assign dsp_a1_o          = dsp_a_q;
  assign dsp_a2_o          = dsp_a_q;
  assign dsp_b1_o          = dsp_b1_q;
  assign dsp_b2_o          = dsp_b2_q;
  assign dsp_load_acc_o    = load_q;

  // Static DSP configuration.
  assign dsp_feedback_o    = 3'b000;
  assign dsp_subtract_o    = 1'b0;
  assign dsp_saturate_o    = 1'b1;
  assign dsp_round_o       = (SHIFT != 0);
  assign dsp_shift_right_o = 5'(SHIFT);
  assign dsp_unsigned_a_o  = (SIGNED_DATA == 0);
  assign dsp_unsigned_b_o  = (SIGNED_DATA == 0);
  assign dsp_acc_fir_o     = 5'd0;

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for dsp19x2_fir_sequencer. A behavioural DSP19X2 MAC (input
// register + accumulator/output register, so DSP_Z follows the last tap by
// two cycles) closes the loop. A transaction-level reference model computes
// the filter result directly as a saturated dot product and predicts, for
// each cycle after acceptance, what the controller must present.
// ---------------------------------------------------------------------------
module tb_dsp19x2_fir_sequencer;

  localparam int NUM_TAPS    = 8;
  localparam int SHIFT       = 0;
  localparam int PIPE_LAT    = 2;
  localparam int SIGNED_DATA = 1;
  localparam int OUT_T       = NUM_TAPS + PIPE_LAT + 1;  // cycles from accept to M_VALID

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_ready;
  logic [8:0]  s_data1 = '0, s_data2 = '0;
  logic        coef_we = 1'b0, coef_ready;
  logic [3:0]  coef_addr = '0;
  logic [9:0]  coef_data = '0;
  logic [9:0]  dsp_a1, dsp_a2;
  logic [8:0]  dsp_b1, dsp_b2;
  logic        dsp_load_acc, dsp_subtract, dsp_saturate, dsp_round;
  logic [2:0]  dsp_feedback;
  logic [4:0]  dsp_shift_right, dsp_acc_fir;
  logic        dsp_unsigned_a, dsp_unsigned_b;
  logic [18:0] dsp_z1, dsp_z2;
  logic        m_valid, m_ready = 1'b1;
  logic [18:0] m_data1, m_data2;
  logic        busy;

  always #5 clk = ~clk;

  dsp19x2_fir_sequencer #(
    .NUM_TAPS(NUM_TAPS), .SHIFT(SHIFT), .PIPE_LAT(PIPE_LAT), .SIGNED_DATA(SIGNED_DATA)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data1_i(s_data1), .s_data2_i(s_data2),
    .coef_we_i(coef_we), .coef_ready_o(coef_ready),
    .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .dsp_a1_o(dsp_a1), .dsp_a2_o(dsp_a2), .dsp_b1_o(dsp_b1), .dsp_b2_o(dsp_b2),
    .dsp_load_acc_o(dsp_load_acc), .dsp_feedback_o(dsp_feedback),
    .dsp_subtract_o(dsp_subtract), .dsp_saturate_o(dsp_saturate),
    .dsp_round_o(dsp_round), .dsp_shift_right_o(dsp_shift_right),
    .dsp_unsigned_a_o(dsp_unsigned_a), .dsp_unsigned_b_o(dsp_unsigned_b),
    .dsp_acc_fir_o(dsp_acc_fir),
    .dsp_z1_i(dsp_z1), .dsp_z2_i(dsp_z2),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data1_o(m_data1), .m_data2_o(m_data2),
    .busy_o(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [18:0] sat19(input longint v);
    if (v > 64'sd262143)  return 19'h3FFFF;
    if (v < -64'sd262144) return 19'h40000;
    return v[18:0];
  endfunction

  always @(posedge clk) cyc++;

  // ---------------- behavioural DSP19X2 (signed MAC, SHIFT = 0) ------------
  logic [9:0] da1_r = '0, da2_r = '0;
  logic [8:0] db1_r = '0, db2_r = '0;
  logic       dload_r = 1'b0;
  longint     acc1 = 0, acc2 = 0;

  always @(posedge clk) begin
    acc1 <= (dload_r ? 64'sd0 : acc1) + longint'($signed(da1_r)) * longint'($signed(db1_r));
    acc2 <= (dload_r ? 64'sd0 : acc2) + longint'($signed(da2_r)) * longint'($signed(db2_r));
    da1_r   <= dsp_a1;
    da2_r   <= dsp_a2;
    db1_r   <= dsp_b1;
    db2_r   <= dsp_b2;
    dload_r <= dsp_load_acc;
  end

  assign dsp_z1 = sat19(acc1);
  assign dsp_z2 = sat19(acc2);

  // ---------------- transaction-level reference model ----------------------
  logic [9:0]  coef_m [NUM_TAPS];
  logic [8:0]  x1_m   [NUM_TAPS];
  logic [8:0]  x2_m   [NUM_TAPS];
  logic [9:0]  snap_c [NUM_TAPS];
  logic [8:0]  snap_x1 [NUM_TAPS];
  logic [8:0]  snap_x2 [NUM_TAPS];
  int          m_t = 0;          // 0: idle, 1..OUT_T-1: computing, OUT_T: result offered
  logic [18:0] res1 = '0, res2 = '0, exp_m1 = '0, exp_m2 = '0;

  always @(posedge clk) begin : model
    longint s1, s2;
    bit     cr;
    if (rst) begin
      m_t    = 0;
      exp_m1 = '0;
      exp_m2 = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_m[i] = '0;
        x1_m[i]   = '0;
        x2_m[i]   = '0;
      end
    end else begin
      cr = (m_t == 0) || (m_t == OUT_T);
      if (coef_we && cr) begin
        for (int i = 0; i < NUM_TAPS; i++)
          if (int'(coef_addr) == i) coef_m[i] = coef_data;
      end
      if (m_t == 0) begin
        if (s_valid) begin
          for (int i = NUM_TAPS - 1; i > 0; i--) begin
            x1_m[i] = x1_m[i-1];
            x2_m[i] = x2_m[i-1];
          end
          x1_m[0] = s_data1;
          x2_m[0] = s_data2;
          s1 = 0;
          s2 = 0;
          for (int i = 0; i < NUM_TAPS; i++) begin
            snap_c[i]  = coef_m[i];
            snap_x1[i] = x1_m[i];
            snap_x2[i] = x2_m[i];
            s1 += longint'($signed(coef_m[i])) * longint'($signed(x1_m[i]));
            s2 += longint'($signed(coef_m[i])) * longint'($signed(x2_m[i]));
          end
          res1 = sat19(s1);
          res2 = sat19(s2);
          m_t  = 1;
        end
      end else if (m_t == OUT_T) begin
        if (m_ready) m_t = 0;
      end else begin
        m_t++;
        if (m_t == OUT_T) begin
          exp_m1 = res1;
          exp_m2 = res2;
        end
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  always @(negedge clk) begin : compare
    logic [9:0] ea;
    logic [8:0] eb1, eb2;
    if (chk_en) begin
      ea  = '0;
      eb1 = '0;
      eb2 = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (m_t == i + 1) begin
          ea  = snap_c[i];
          eb1 = snap_x1[i];
          eb2 = snap_x2[i];
        end
      end
      check("s_ready",    s_ready,      (m_t == 0));
      check("coef_ready", coef_ready,   (m_t == 0) || (m_t == OUT_T));
      check("m_valid",    m_valid,      (m_t == OUT_T));
      check("busy",       busy,         (m_t >= 1) && (m_t < OUT_T));
      check("load_acc",   dsp_load_acc, (m_t == 1));
      check("dsp_a1",     dsp_a1, ea);
      check("dsp_a2",     dsp_a2, ea);
      check("dsp_b1",     dsp_b1, eb1);
      check("dsp_b2",     dsp_b2, eb2);
      check("m_data1",    m_data1, exp_m1);
      check("m_data2",    m_data2, exp_m2);
    end
  end

  // ---------------- result monitor -----------------------------------------
  typedef struct {
    logic [18:0] d1;
    logic [18:0] d2;
  } res_t;
  res_t res_q[$];
  logic mv_prev = 1'b0;

  always @(negedge clk) begin
    if (m_valid && !mv_prev) res_q.push_back('{d1: m_data1, d2: m_data2});
    mv_prev = m_valid;
  end

  // ---------------- driver helpers (called at a negedge) -------------------
  task automatic wait_idle();
    int n = 0;
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("idle_timeout", s_ready, 1);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [9:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Returns in the cycle after the accept edge (tap 0 on the DSP inputs).
  task automatic send(input logic [8:0] d1, input logic [8:0] d2);
    s_valid = 1'b1;
    s_data1 = d1;
    s_data2 = d2;
    wait_idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic get_result(output logic [18:0] r1, output logic [18:0] r2);
    res_t r;
    int n = 0;
    while (res_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL result_timeout: got no M_VALID within %0d cycles", n);
      r1 = 'x;
      r2 = 'x;
    end else begin
      r  = res_q.pop_front();
      r1 = r.d1;
      r2 = r.d2;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus --------------------------------------
  initial begin : stim
    logic [18:0] r1, r2;
    int acc_cyc [9];
    logic [8:0] imp1 [9];
    logic [8:0] imp2 [9];

    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Reset values.
    check("rst_s_ready",    s_ready, 1);
    check("rst_coef_ready", coef_ready, 1);
    check("rst_m_valid",    m_valid, 0);
    check("rst_busy",       busy, 0);
    check("rst_m_data1",    m_data1, 0);
    check("rst_m_data2",    m_data2, 0);
    check("rst_dsp_a1",     dsp_a1, 0);
    check("rst_dsp_b2",     dsp_b2, 0);
    check("rst_load",       dsp_load_acc, 0);
    check("cfg_feedback",   dsp_feedback, 0);
    check("cfg_subtract",   dsp_subtract, 0);
    check("cfg_saturate",   dsp_saturate, 1);
    check("cfg_round",      dsp_round, 0);
    check("cfg_shift",      dsp_shift_right, 0);
    check("cfg_unsigned",   {dsp_unsigned_a, dsp_unsigned_b}, 0);
    check("cfg_acc_fir",    dsp_acc_fir, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // coef[k] = k+1; an out-of-range address must be ignored.
    for (int k = 0; k < NUM_TAPS; k++) write_coef(4'(k), 10'(k + 1));
    write_coef(4'd9, 10'h3FF);

    // Impulse streamed with S_VALID and M_READY held high.
    for (int i = 0; i < 9; i++) begin
      imp1[i] = (i == 0) ? 9'h001 : 9'h000;
      imp2[i] = (i == 0) ? 9'h1FF : 9'h000;
    end
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data1 = imp1[i];
      s_data2 = imp2[i];
      wait_idle();
      acc_cyc[i] = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int i = 1; i < 9; i++) check("stream_period", acc_cyc[i] - acc_cyc[i-1], 12);
    for (int i = 0; i < 9; i++) begin
      get_result(r1, r2);
      check("impulse_l1", r1, (i < 8) ? 19'(i + 1) : 19'd0);
      check("impulse_l2", r2, (i < 8) ? 19'(-(i + 1)) : 19'd0);
    end

    // Backpressure: result held for 5 cycles, then the next sample goes in
    // the cycle after the handshake.
    wait_idle();
    m_ready = 1'b0;
    send(9'd4, 9'h1FE);
    get_result(r1, r2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid",    m_valid, 1);
      check("bp_m_data1",    m_data1, 19'd4);
      check("bp_m_data2",    m_data2, 19'h7FFFE);
      check("bp_s_ready",    s_ready, 0);
      check("bp_coef_ready", coef_ready, 1);
    end
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data1 = 9'd0;
    s_data2 = 9'd0;
    @(negedge clk);
    check("bp_next_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    check("bp_result1", r1, 19'd4);
    check("bp_result2", r2, 19'h7FFFE);
    get_result(r1, r2);
    check("bp_follow1", r1, 19'd8);
    check("bp_follow2", r2, 19'h7FFFC);

    // Coefficient write during MAC is dropped.
    wait_idle();
    send(9'd0, 9'd0);
    coef_we   = 1'b1;
    coef_addr = 4'd2;
    coef_data = 10'h155;
    check("mac_coef_ready", coef_ready, 0);
    @(negedge clk);
    coef_we = 1'b0;
    get_result(r1, r2);
    check("mac_write_l1", r1, 19'd12);
    check("mac_write_l2", r2, 19'h7FFFA);

    // Coefficient write to tap 0 on the accept edge is used immediately.
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 10'd7;
    s_valid   = 1'b1;
    s_data1   = 9'd5;
    s_data2   = 9'd1;
    @(negedge clk);
    coef_we = 1'b0;
    s_valid = 1'b0;
    get_result(r1, r2);
    check("simul_l1", r1, 19'd51);
    check("simul_l2", r2, 19'h7FFFF);

    // Saturation: 8 x 511 x -256 clamps to the most negative 19-bit value.
    wait_idle();
    for (int k = 0; k < NUM_TAPS; k++) write_coef(4'(k), 10'h1FF);
    for (int i = 0; i < 8; i++) begin
      send(9'h100, 9'h100);
      get_result(r1, r2);
    end
    check("sat_l1", r1, 19'h40000);
    check("sat_l2", r2, 19'h40000);

    // Reset in MAC tap 3 discards the transaction and clears history.
    wait_idle();
    send(9'd1, 9'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rmac_s_ready", s_ready, 1);
    check("rmac_m_valid", m_valid, 0);
    check("rmac_busy",    busy, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rmac_no_result", res_q.size(), 0);
    for (int k = 0; k < NUM_TAPS; k++) write_coef(4'(k), 10'd1);
    send(9'd1, 9'd1);
    get_result(r1, r2);
    check("rmac_impulse_l1", r1, 19'd1);
    check("rmac_impulse_l2", r2, 19'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
